// File: rtl/bno055_euler_poller.sv
// bno055_euler_poller: per-tick six-byte Euler read sequencer for the BNO055 byte reader.
// Define CHIP_ID_CHECK_EN to gate Euler frames on a successful chip-ID (0xA0) read.
module bno055_euler_poller #(
  parameter int unsigned CLK_HZ         = 25_000_000,
  parameter int unsigned POLL_HZ        = 100,
  parameter int unsigned TIMEOUT_CYCLES = 250_000,
  parameter logic [7:0]  BASE_ADDR      = 8'h1A
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_enable,
  output logic [7:0]  o_reg_addr,
  output logic        o_read_start,
  input  logic [7:0]  i_rd_data,
  input  logic        i_rd_done,
  output logic [15:0] o_heading,
  output logic [15:0] o_roll,
  output logic [15:0] o_pitch,
  output logic        o_valid,
  output logic        o_busy,
  output logic        o_timeout_err
);

  localparam int unsigned TICK_DIV = CLK_HZ / POLL_HZ;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int OW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
  localparam logic [OW-1:0] TOUT_MAX = OW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_PUBLISH
`ifdef CHIP_ID_CHECK_EN
    ,
    S_ID_ISSUE,
    S_ID_WAIT
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [2:0]      idx_q, idx_d;
  logic [TW-1:0]   cnt_q, cnt_d;
  logic [OW-1:0]   tout_q, tout_d;
  logic [5:0][7:0] slot_q, slot_d;
  logic [7:0]      addr_q, addr_d;
  logic            start_q, start_d;
  logic [15:0]     head_q, head_d;
  logic [15:0]     roll_q, roll_d;
  logic [15:0]     pitch_q, pitch_d;
  logic            valid_q, valid_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            tick;
`ifdef CHIP_ID_CHECK_EN
  logic            id_ok_q, id_ok_d;
`endif

  always_comb begin
    tick    = (cnt_q == TICK_MAX);
    cnt_d   = tick ? '0 : cnt_q + TW'(1);
    state_d = state_q;
    idx_d   = idx_q;
    tout_d  = tout_q;
    slot_d  = slot_q;
    addr_d  = addr_q;
    start_d = 1'b0;
    head_d  = head_q;
    roll_d  = roll_q;
    pitch_d = pitch_q;
    valid_d = 1'b0;
    err_d   = 1'b0;
`ifdef CHIP_ID_CHECK_EN
    id_ok_d = id_ok_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (i_enable && tick) begin
          idx_d = '0;
`ifdef CHIP_ID_CHECK_EN
          state_d = id_ok_q ? S_ISSUE : S_ID_ISSUE;
`else
          state_d = S_ISSUE;
`endif
        end
      end
      S_ISSUE: begin
        addr_d  = BASE_ADDR + {5'd0, idx_q};
        start_d = 1'b1;
        tout_d  = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (i_rd_done) begin
          slot_d[idx_q] = i_rd_data;
          state_d = S_NEXT;
        end else if (tout_q == TOUT_MAX) begin
          err_d   = 1'b1;
          slot_d  = '0;
          state_d = S_IDLE;
        end else begin
          tout_d = tout_q + OW'(1);
        end
      end
      S_NEXT: begin
        // Results are loaded on entry so they are visible during S_PUBLISH.
        if (idx_q == 3'd5) begin
          head_d  = {slot_q[1], slot_q[0]};
          roll_d  = {slot_q[3], slot_q[2]};
          pitch_d = {slot_q[5], slot_q[4]};
          valid_d = 1'b1;
          state_d = S_PUBLISH;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = S_ISSUE;
        end
      end
      S_PUBLISH: state_d = S_IDLE;
`ifdef CHIP_ID_CHECK_EN
      S_ID_ISSUE: begin
        addr_d  = 8'h00;
        start_d = 1'b1;
        tout_d  = '0;
        state_d = S_ID_WAIT;
      end
      S_ID_WAIT: begin
        if (i_rd_done) begin
          if (i_rd_data == 8'hA0) begin
            id_ok_d = 1'b1;
            idx_d   = '0;
            state_d = S_ISSUE;
          end else begin
            err_d   = 1'b1;
            state_d = S_IDLE;
          end
        end else if (tout_q == TOUT_MAX) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tout_d = tout_q + OW'(1);
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      tout_q  <= '0;
      slot_q  <= '0;
      addr_q  <= '0;
      start_q <= 1'b0;
      head_q  <= '0;
      roll_q  <= '0;
      pitch_q <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CHIP_ID_CHECK_EN
      id_ok_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      tout_q  <= tout_d;
      slot_q  <= slot_d;
      addr_q  <= addr_d;
      start_q <= start_d;
      head_q  <= head_d;
      roll_q  <= roll_d;
      pitch_q <= pitch_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
`ifdef CHIP_ID_CHECK_EN
      id_ok_q <= id_ok_d;
`endif
    end
  end

  assign o_reg_addr    = addr_q;
  assign o_read_start  = start_q;
  assign o_heading     = head_q;
  assign o_roll        = roll_q;
  assign o_pitch       = pitch_q;
  assign o_valid       = valid_q;
  assign o_busy        = busy_q;
  assign o_timeout_err = err_q;

endmodule

// File: tb/tb_bno055_euler_poller.sv
// tb_bno055_euler_poller: table, random and corner-case sequences against a
// behavioural responder and event-timing model of the Euler poller.
`timescale 1ns/1ps
module tb_bno055_euler_poller;

  localparam int D = 60;
  localparam int T = 100;
  localparam logic [7:0] BASE = 8'h1A;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [7:0]  rd_data = 8'h00;
  logic        rd_done = 1'b0;
  logic [7:0]  o_reg_addr;
  logic        o_read_start;
  logic [15:0] o_heading;
  logic [15:0] o_roll;
  logic [15:0] o_pitch;
  logic        o_valid;
  logic        o_busy;
  logic        o_timeout_err;

  bno055_euler_poller #(
    .CLK_HZ(600),
    .POLL_HZ(10),
    .TIMEOUT_CYCLES(T),
    .BASE_ADDR(BASE)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_enable(en),
    .o_reg_addr(o_reg_addr),
    .o_read_start(o_read_start),
    .i_rd_data(rd_data),
    .i_rd_done(rd_done),
    .o_heading(o_heading),
    .o_roll(o_roll),
    .o_pitch(o_pitch),
    .o_valid(o_valid),
    .o_busy(o_busy),
    .o_timeout_err(o_timeout_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  // Responder and event log
  int ncyc = 0;
  int r_cyc = 0;
  int done_cyc = -1000;
  int start_cyc = 0;
  int valid_cyc = 0;
  int n_done = 0;
  int n_start = 0;
  int valid_cnt = 0;
  int err_cnt = 0;
  logic prev_rst = 1'b0;
  logic [7:0] last_addr = 8'hFF;
  logic [7:0] first_addr = 8'hFF;
  bit need_first = 1'b0;
  logic [7:0] alog[$];
  bit resp_on = 1'b1;
  bit rand_lat = 1'b0;
  int lat = 20;
  logic [7:0] drop_addr = 8'hFF;
  logic [7:0] id_val = 8'hA0;
  logic [7:0] mem[6];
  bit pend = 1'b0;
  int cd = 0;
  logic [7:0] pdata = 8'h00;

  always @(negedge clk) begin
    int ai;
    ncyc++;
    if (rst_n && !prev_rst) begin
      r_cyc = ncyc;
      need_first = 1'b1;
    end
    prev_rst = rst_n;
    if (rd_done) rd_done = 1'b0;
    if (pend) begin
      cd--;
      if (cd == 0) begin
        rd_data = pdata;
        rd_done = 1'b1;
        pend = 1'b0;
        done_cyc = ncyc;
        n_done++;
      end
    end
    if (rst_n && o_read_start) begin
      chk("no_restart", int'(pend), 0);
      if (o_reg_addr > BASE && o_reg_addr <= BASE + 8'd5) begin
        chk("byte_gap", ncyc - done_cyc, 3);
        chk("addr_seq", int'(o_reg_addr), int'(last_addr) + 1);
      end else if (o_reg_addr == BASE && last_addr == 8'h00) begin
        chk("id_to_frame", ncyc - done_cyc, 2);
      end else begin
        chk("tick_align", (ncyc - 2 - r_cyc) % D, D - 1);
      end
      if (need_first) begin
        first_addr = o_reg_addr;
        need_first = 1'b0;
      end
      last_addr = o_reg_addr;
      start_cyc = ncyc;
      n_start++;
      alog.push_back(o_reg_addr);
      if (resp_on && o_reg_addr != drop_addr) begin
        pend = 1'b1;
        cd = rand_lat ? int'($urandom_range(1, 40)) : lat;
        ai = int'(o_reg_addr) - int'(BASE);
        pdata = (o_reg_addr == 8'h00) ? id_val : mem[ai];
      end
    end
    if (rst_n && o_valid) begin
      chk("valid_lat", ncyc - done_cyc, 2);
      chk("valid_last_addr", int'(last_addr), int'(BASE) + 5);
      valid_cnt++;
      valid_cyc = ncyc;
    end
    if (rst_n && o_timeout_err) begin
      if (done_cyc > start_cyc) chk("id_err_lat", ncyc - done_cyc, 1);
      else chk("tout_lat", ncyc - start_cyc, T);
      err_cnt++;
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #2;
  endtask

  function automatic int cnt_of(input int w);
    case (w)
      0: return valid_cnt;
      1: return err_cnt;
      2: return n_start;
      default: return n_done;
    endcase
  endfunction

  task automatic wait_for(input string nm, input int w, input int target, input int maxc);
    int k = 0;
    while (cnt_of(w) < target && k < maxc) begin
      cyc1();
      k++;
    end
    if (cnt_of(w) < target) chk({"bound_", nm}, cnt_of(w), target);
  endtask

  task automatic run_frame(input string nm, input int maxv);
    int s0 = n_start;
    int v0 = valid_cnt;
    en = 1'b1;
    wait_for({nm, "_start"}, 2, s0 + 1, 2 * D + 10);
    en = 1'b0;
    wait_for({nm, "_valid"}, 0, v0 + 1, maxv);
    repeat (4) cyc1();
    chk({nm, "_one_valid"}, valid_cnt - v0, 1);
  endtask

  task automatic chk_mem_vals(input string nm);
    chk({nm, "_heading"}, int'(o_heading), int'({mem[1], mem[0]}));
    chk({nm, "_roll"}, int'(o_roll), int'({mem[3], mem[2]}));
    chk({nm, "_pitch"}, int'(o_pitch), int'({mem[5], mem[4]}));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_addr"}, int'(o_reg_addr), 0);
    chk({nm, "_start"}, int'(o_read_start), 0);
    chk({nm, "_heading"}, int'(o_heading), 0);
    chk({nm, "_roll"}, int'(o_roll), 0);
    chk({nm, "_pitch"}, int'(o_pitch), 0);
    chk({nm, "_valid"}, int'(o_valid), 0);
    chk({nm, "_busy"}, int'(o_busy), 0);
    chk({nm, "_err"}, int'(o_timeout_err), 0);
  endtask

  typedef struct {
    int          lat;
    logic [47:0] bytes;
    logic [15:0] h;
    logic [15:0] r;
    logic [15:0] p;
  } vec_t;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vt[4];
    logic [15:0] ph, pr, pp;
    int s0, v0, e0, d0, t, n;
    vt[0] = '{20, 48'h0020_FFF0_0B10, 16'h0B10, 16'hFFF0, 16'h0020};
    vt[1] = '{3,  48'h0001_7FFF_8000, 16'h8000, 16'h7FFF, 16'h0001};
    vt[2] = '{1,  48'h1234_0000_FFFF, 16'hFFFF, 16'h0000, 16'h1234};
    vt[3] = '{7,  48'h8000_3CC3_A55A, 16'hA55A, 16'h3CC3, 16'h8000};
    for (int i = 0; i < 6; i++) mem[i] = vt[0].bytes[8*i +: 8];

    repeat (3) cyc1();
    chk_zero("reset");
    rst_n = 1'b1;
    cyc1();

`ifdef CHIP_ID_CHECK_EN
    id_val = 8'h55;
    lat = 20;
    s0 = n_start;
    e0 = err_cnt;
    en = 1'b1;
    wait_for("id_bad_err", 1, e0 + 1, 2 * D + T + 50);
    en = 1'b0;
    chk("id_bad_starts", n_start - s0, 1);
    chk("id_bad_addr", int'(last_addr), 0);
    chk("id_bad_no_valid", valid_cnt, 0);
    chk("first_addr", int'(first_addr), 0);
    id_val = 8'hA0;
    repeat (D) cyc1();
    run_frame("id_good", 7 * 45 + 2 * D);
    chk("id_good_seq0", int'(alog[alog.size() - 7]), 0);
`else
    chk("first_addr_pending", int'(need_first), 1);
`endif

    for (int v = 0; v < 4; v++) begin
      lat = vt[v].lat;
      for (int i = 0; i < 6; i++) mem[i] = vt[v].bytes[8*i +: 8];
      run_frame("table", 6 * (lat + 4) + 10);
      chk("table_heading", int'(o_heading), int'(vt[v].h));
      chk("table_roll", int'(o_roll), int'(vt[v].r));
      chk("table_pitch", int'(o_pitch), int'(vt[v].p));
      for (int k = 0; k < 6; k++)
        chk("table_addr", int'(alog[alog.size() - 6 + k]), int'(BASE) + k);
`ifndef CHIP_ID_CHECK_EN
      if (v == 0) chk("first_addr", int'(first_addr), int'(BASE));
`endif
    end

    rand_lat = 1'b1;
    for (int f = 0; f < 6; f++) begin
      for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
      run_frame("rand", 6 * 45 + 10);
      chk_mem_vals("rand");
    end
    rand_lat = 1'b0;

    ph = o_heading;
    pr = o_roll;
    pp = o_pitch;
    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
    drop_addr = BASE + 8'd3;
    lat = 10;
    s0 = n_start;
    v0 = valid_cnt;
    e0 = err_cnt;
    en = 1'b1;
    wait_for("tout_start4", 2, s0 + 4, 2 * D + 80);
    en = 1'b0;
    chk("tout_addr", int'(last_addr), int'(BASE) + 3);
    wait_for("tout_err", 1, e0 + 1, T + 20);
    cyc1();
    chk("tout_one_err", err_cnt - e0, 1);
    chk("tout_no_valid", valid_cnt - v0, 0);
    chk("tout_keep_heading", int'(o_heading), int'(ph));
    chk("tout_keep_roll", int'(o_roll), int'(pr));
    chk("tout_keep_pitch", int'(o_pitch), int'(pp));
    chk("tout_idle", int'(o_busy), 0);
    drop_addr = 8'hFF;

    lat = 90;
    for (int i = 0; i < 6; i++) mem[i] = 8'($urandom);
    v0 = valid_cnt;
    en = 1'b1;
    wait_for("drop_valid1", 0, v0 + 1, 6 * 95 + 2 * D);
    s0 = n_start;
    wait_for("drop_start2", 2, s0 + 1, 2 * D + 5);
    en = 1'b0;
    t = valid_cyc + 1;
    while ((t - r_cyc) % D != D - 1) t++;
    chk("tick_drop_start", start_cyc, t + 2);
    chk("tick_drop_addr", int'(last_addr), int'(BASE));
    wait_for("drop_valid2", 0, v0 + 2, 6 * 95 + 10);
    chk_mem_vals("tick_drop");

    lat = 5;
    for (int i = 0; i < 6; i++) mem[i] = vt[1].bytes[8*i +: 8];
    d0 = n_done;
    v0 = valid_cnt;
    en = 1'b1;
    wait_for("en_drop_done2", 3, d0 + 2, 2 * D + 30);
    en = 1'b0;
    wait_for("en_drop_valid", 0, v0 + 1, 6 * 10);
    chk("en_drop_heading", int'(o_heading), int'(vt[1].h));
    chk("en_drop_pitch", int'(o_pitch), int'(vt[1].p));
    s0 = n_start;
    repeat (3 * D) cyc1();
    chk("en_drop_no_start", n_start - s0, 0);
    chk("en_drop_idle", int'(o_busy), 0);

    lat = 30;
    for (int i = 0; i < 6; i++) mem[i] = vt[2].bytes[8*i +: 8];
    s0 = n_start;
    en = 1'b1;
    wait_for("rst_start3", 2, s0 + 3, 2 * D + 80);
    chk("rst_at_byte2", int'(last_addr), int'(BASE) + 2);
    repeat (5) cyc1();
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    cyc1();
    cyc1();
    rst_n = 1'b1;
    s0 = n_start;
    v0 = valid_cnt;
    d0 = n_done;
    wait_for("rst_stale_done", 3, d0 + 1, 40);
    cyc1();
    cyc1();
    chk("rst_stale_idle", int'(o_busy), 0);
    chk("rst_stale_no_start", n_start - s0, 0);
    chk("rst_stale_no_valid", valid_cnt - v0, 0);
    wait_for("rst_restart", 2, s0 + 1, 2 * D);
    chk("rst_restart_cyc", start_cyc, r_cyc + D + 1);
`ifdef CHIP_ID_CHECK_EN
    chk("rst_restart_addr", int'(first_addr), 0);
`else
    chk("rst_restart_addr", int'(first_addr), int'(BASE));
`endif
    en = 1'b0;
    wait_for("rst_valid", 0, v0 + 1, 7 * 35 + 10);
    chk_mem_vals("rst_frame");

    n = 0;
    repeat (5) cyc1();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
